// File: rtl/tx_scheduler_pkg.sv
// Shared types and helpers for the transmit-side scheduler and its arbiter.
package tx_scheduler_pkg;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} sched_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requester above `last`, else lowest overall.
module rr_arbiter import tx_scheduler_pkg::*; #(
  parameter int NUM_REQ = 4,
  localparam int IW = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  assign any = |req;

  // Descending scans so the lowest qualifying index is the one left in idx.
  always_comb begin
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i]) idx = IW'(i);
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i] && (IW'(i) > last)) idx = IW'(i);
    grant = '0;
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/tx_scheduler.sv
// Shares one UART transmitter between NUM_REQ byte producers, one byte per grant,
// with a start timeout and an inter-frame gap before re-arbitration.
module tx_scheduler import tx_scheduler_pkg::*; #(
  parameter int NUM_REQ       = 4,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 1023,
  localparam int IW = clog2(NUM_REQ)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_send,
  output logic [7:0]           tx_data,
  input  logic                 tx_active,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [IW-1:0]        grant_id,
  output logic                 timeout
);

  localparam int CMAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
  localparam int CW   = (CMAX < 1) ? 1 : clog2(CMAX + 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(START_TIMEOUT);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  // With no gap the frame end returns straight to IDLE, which still holds one clock.
  localparam sched_state_t POST_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

  sched_state_t              state;
  logic [CW-1:0]             cnt;
  logic [IW-1:0]             last;
  logic [NUM_REQ-1:0]        win_grant;
  logic [IW-1:0]             win_idx;
  logic                      win_any;
  logic [NUM_REQ-1:0][7:0]   req_bytes;

  assign req_bytes = req_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .last  (last),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign req_ready = (state == IDLE && reset_n) ? win_grant : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= IW'(NUM_REQ - 1);
      tx_send  <= 1'b0;
      tx_data  <= '0;
      grant_id <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: if (win_any) begin
          tx_data  <= req_bytes[win_idx];
          grant_id <= win_idx;
          last     <= win_idx;
          cnt      <= '0;
          tx_send  <= 1'b1;
          state    <= LAUNCH;
        end
        LAUNCH: if (tx_active) begin
          tx_send <= 1'b0;
          state   <= WAIT_DONE;
        end else if (cnt == ST_LAST) begin
          timeout <= 1'b1;
          tx_send <= 1'b0;
          cnt     <= '0;
          state   <= POST_FRAME;
        end else begin
          cnt <= cnt + 1'b1;
        end
        // Entered only after tx_active, so a stale done cannot end the frame early.
        WAIT_DONE: if (tx_done && !tx_active) begin
          cnt   <= '0;
          state <= POST_FRAME;
        end
        GAP: if (cnt == GAP_LAST) state <= IDLE;
             else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tx_scheduler.md
Name: tx_scheduler

Overview:
- Round-robin scheduler that shares one UART transmitter between NUM_REQ byte producers.
- Accepts one byte per grant over a valid/ready handshake.
- Drives the transmitter's send/data_in, waits for the transmitter's active/done flags, then enforces an inter-frame gap before re-arbitrating.
- Sits between the producer blocks and the Tx unit, in the Tx clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 16, system clocks of idle between frames (0 allowed).
- START_TIMEOUT, 1023, clocks to wait for tx_active after raising tx_send before aborting.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*8  packed bytes; requester i occupies bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot accept strobe.
- tx_send  out  1  to transmitter send.
- tx_data  out  8  to transmitter data_in; held stable for the whole frame.
- tx_active  in  1  transmitter active_flag.
- tx_done  in  1  transmitter done_flag.
- busy  out  1  high whenever state is not IDLE.
- grant_id  out  clog2(NUM_REQ)  index of the last accepted requester.
- timeout  out  1  one-clock pulse when the start timeout fires.

Behaviour:
- **Reset values:**
  - state=IDLE, tx_send=0, tx_data=0, grant_id=0, timeout=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
  - req_ready=0 while reset_n is low; it is gated combinationally.
  - Reset mid-frame aborts immediately; the byte is lost.
- **IDLE:**
  - winner = first i with req_valid[i] set, scanning last+1, last+2, ... modulo NUM_REQ.
  - req_ready[winner] is asserted combinationally in IDLE only; no ready when no valid.
  - On the accepting edge: tx_data<=req_data[winner], grant_id<=winner, last<=winner, counter cleared, go LAUNCH.
  - Exactly one transfer per grant.
- **LAUNCH:**
  - tx_send=1 (registered; rises the clock after acceptance).
  - If tx_active=1: go WAIT_DONE; tx_send is 0 from the next clock.
  - Else if counter reaches START_TIMEOUT: pulse timeout for one clock, tx_send=0, go GAP.
  - Otherwise the counter increments.
- **WAIT_DONE:**
  - tx_send=0.
  - Leave when tx_done=1 and tx_active=0, then go GAP with the counter cleared.
  - A tx_done that is high before tx_active was seen is ignored, because this state is entered only after tx_active.
  - No timeout in this state.
- **GAP:**
  - Count GAP_CYCLES clocks, then go IDLE.
  - If GAP_CYCLES=0, go directly to IDLE on the next edge, so IDLE is occupied one clock minimum.
- **Timing and arbitration rules:**
  - Minimum spacing between consecutive accepts is frame time + GAP_CYCLES + 2 clocks.
  - Requesters not granted keep valid asserted; the scheduler never drops a non-accepted byte.
  - req_data changes while a request is pending are sampled only at the accept edge.
  - Simultaneous valid from all requesters: grant order is strictly rotating.
  - A single persistent requester is re-granted every frame.
- **Widths:** counter width is clog2(max(START_TIMEOUT, GAP_CYCLES)+1).

Decomposition:
- Shared package: state encoding typedef (IDLE, LAUNCH, WAIT_DONE, GAP) and the clog2 helper function.
- Sub-module rr_arbiter (NUM_REQ): combinational.
  - Inputs: req and last pointer.
  - Outputs: one-hot grant and index.
  - Reusable by the future Rx-side scheduler.
- Everything else lives in tx_scheduler.

Test Plan:
- **Single request:** NUM_REQ=4, GAP_CYCLES=16, TxUnit behavioural model.
  - Stimulus: reset, then req_valid=4'b0001 with byte 0xA5.
  - Required: req_ready[0] pulses once, tx_data=0xA5, tx_send high until tx_active, busy low exactly 16 clocks after done+1.
- **Round-robin:** req_valid=4'b1111 with bytes 0x11, 0x22, 0x33, 0x44.
  - Required: grant_id sequence 0,1,2,3,0; each byte transmitted once in that order on the serial line.
- **Pointer rotation:** after a grant to 2, req_valid=4'b0101.
  - Required: next grant is 0; the one after is 2.
- **Start timeout:** START_TIMEOUT=1023 and the model never raises tx_active.
  - Required: timeout pulses exactly 1024 clocks after tx_send rose; tx_send drops; next request is granted after the gap.
- **Reset mid-frame:** reset_n low during WAIT_DONE.
  - Required: tx_send=0, busy=0, req_ready=0 asynchronously.
  - After release, requester 0 has priority again.
- **Zero gap and stale done:** GAP_CYCLES=0, with tx_done held high before the frame starts.
  - Required: the scheduler still waits for tx_active before honouring done; back-to-back frames separated by exactly 2 scheduler clocks.
